// File: rtl/beta_dmem_resp.sv
// beta_dmem_resp: data-memory responder for the Beta datapath.
// Services LD/LDR (MOE) and ST (MWR) requests against a word-addressed
// on-chip RAM. It inserts WAIT_STATES extra cycles before each access and
// holds the processor on STALL until the access completes.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no transaction; a request latches address/data/op
//   S_WAIT   | counting down wait states; request drop aborts
//   S_ACCESS | RAM write or MRD load at the closing edge; drop aborts
//   S_DONE   | result visible, STALL low, processor advances
module beta_dmem_resp #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        MOE,
   input  logic        MWR,
   input  logic [31:0] MA,
   input  logic [31:0] MWD,
   output logic [31:0] MRD,
   output logic        STALL,
   output logic        MERR
);

   localparam int         WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            cnt;
   logic [3:0]            cnt_nxt;

   logic                  req;
   logic                  oor;
   logic                  do_access;
   logic                  unused_ma_lsb;

   logic [DEPTH_LOG2-1:0] idx_q;
   logic [31:0]           wd_q;
   logic                  wr_q;
   logic                  oor_q;
   logic                  both_q;

   logic [31:0]           mem [WORDS];

   assign req           = MOE | MWR;
   assign oor           = |MA[31:DEPTH_LOG2+2];
   assign unused_ma_lsb = ^MA[1:0];

   // The access only takes effect if the request is still present; a drop
   // here (e.g. an interrupt squashing the store) abandons the transaction.
   assign do_access = (state == S_ACCESS) && req;

   // State register and wait-state down-counter
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            cnt_nxt = 4'd0;
            if (req) begin
               cnt_nxt   = CNT_INIT;
               state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nxt = S_ACCESS;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACCESS: begin
            state_nxt = req ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // STALL: hold the processor from the request cycle through ACCESS;
   // forced low while in reset even if a request is still asserted.
   always_comb begin
      STALL = 1'b0;
      if (RESET_N) begin
         case (state)
            S_IDLE:   STALL = req;
            S_WAIT:   STALL = 1'b1;
            S_ACCESS: STALL = 1'b1;
            default:  STALL = 1'b0;
         endcase
      end
   end

   // Capture address, data and operation when a transaction starts;
   // later changes on MA/MWD are ignored until the next IDLE.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idx_q  <= '0;
         wd_q   <= 32'h0;
         wr_q   <= 1'b0;
         oor_q  <= 1'b0;
         both_q <= 1'b0;
      end else if ((state == S_IDLE) && req) begin
         idx_q  <= MA[DEPTH_LOG2+1:2];
         wd_q   <= MWD;
         wr_q   <= MWR;
         oor_q  <= oor;
         both_q <= MOE & MWR;
      end
   end

   // Read data and error pulse, both registered at the edge ending ACCESS
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         MRD  <= 32'h0;
         MERR <= 1'b0;
      end else begin
         MERR <= do_access && (oor_q || both_q);
         if (do_access && !wr_q) begin
            MRD <= oor_q ? 32'h0 : mem[idx_q];
         end
      end
   end

   // RAM write port; contents are deliberately not reset
   always_ff @(posedge CLK) begin
      if (RESET_N && do_access && wr_q && !oor_q) begin
         mem[idx_q] <= wd_q;
      end
   end

endmodule

// File: tb/tb_beta_dmem_resp.sv
// Directed bench for beta_dmem_resp. Three instances differ only in
// WAIT_STATES (0, 1, 3); each has its own stimulus and reset wires.
module tb_beta_dmem_resp;

   logic        clk;
   logic        rst_n [3];
   logic        moe   [3];
   logic        mwr   [3];
   logic [31:0] ma    [3];
   logic [31:0] mwd   [3];
   logic [31:0] mrd   [3];
   logic        stall [3];
   logic        merr  [3];

   int nvec = 0;
   int nerr = 0;

   beta_dmem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
      .CLK(clk), .RESET_N(rst_n[0]), .MOE(moe[0]), .MWR(mwr[0]),
      .MA(ma[0]), .MWD(mwd[0]), .MRD(mrd[0]), .STALL(stall[0]), .MERR(merr[0]));

   beta_dmem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
      .CLK(clk), .RESET_N(rst_n[1]), .MOE(moe[1]), .MWR(mwr[1]),
      .MA(ma[1]), .MWD(mwd[1]), .MRD(mrd[1]), .STALL(stall[1]), .MERR(merr[1]));

   beta_dmem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
      .CLK(clk), .RESET_N(rst_n[2]), .MOE(moe[2]), .MWR(mwr[2]),
      .MA(ma[2]), .MWD(mwd[2]), .MRD(mrd[2]), .STALL(stall[2]), .MERR(merr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on instance k, started at a negedge. Counts STALL-high
   // cycles (bounded), scrambles MA/MWD after the first edge to prove they
   // were latched, and checks the DONE cycle. Requests drop in DONE.
   task automatic xact(input int k, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int exp_n, input logic chk_mrd,
                       input logic [31:0] exp_mrd, input logic exp_merr);
      int   n;
      logic merr_seen;
      @(negedge clk);
      mwr[k] = wr;
      moe[k] = rd;
      ma[k]  = addr;
      mwd[k] = data;
      #1;
      n = 0;
      merr_seen = 1'b0;
      while (stall[k] === 1'b1 && n < 40) begin
         merr_seen = merr_seen | merr[k];
         n++;
         @(negedge clk);
         if (n == 1) begin
            ma[k]  = 32'h0000_0FFC;
            mwd[k] = ~data;
         end
         #1;
      end
      check($sformatf("stall_len[%0d]@%h", k, addr), n, exp_n);
      check($sformatf("merr_early[%0d]@%h", k, addr), {31'b0, merr_seen}, 32'h0);
      check($sformatf("merr_done[%0d]@%h", k, addr), {31'b0, merr[k]}, {31'b0, exp_merr});
      if (chk_mrd) check($sformatf("mrd[%0d]@%h", k, addr), mrd[k], exp_mrd);
      moe[k] = 1'b0;
      mwr[k] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         moe[i]   = 1'b0;
         mwr[i]   = 1'b0;
         ma[i]    = 32'h0;
         mwd[i]   = 32'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_stall[%0d]", i), {31'b0, stall[i]}, 32'h0);
         check($sformatf("rst_mrd[%0d]", i), mrd[i], 32'h0);
         check($sformatf("rst_merr[%0d]", i), {31'b0, merr[i]}, 32'h0);
      end
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      @(negedge clk);
      #1;
      check("idle_no_req_stall", {31'b0, stall[0]}, 32'h0);

      // WAIT_STATES=1: store then load, 3 stall cycles each
      xact(1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 3, 1'b1, 32'h0, 1'b0);
      xact(1, 1'b0, 1'b1, 32'h10, 32'h0,         3, 1'b1, 32'hDEAD_BEEF, 1'b0);

      // WAIT_STATES=0: preload words 0/1, then back-to-back loads
      xact(0, 1'b1, 1'b0, 32'h0, 32'h1, 2, 1'b0, 32'h0, 1'b0);
      xact(0, 1'b1, 1'b0, 32'h4, 32'h2, 2, 1'b0, 32'h0, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h0, 32'h0, 2, 1'b1, 32'h1, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h4, 32'h0, 2, 1'b1, 32'h2, 1'b0);

      // Out-of-range store is dropped, out-of-range load returns zero
      xact(0, 1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, 2, 1'b1, 32'h2, 1'b1);
      xact(0, 1'b0, 1'b1, 32'h0,    32'h0,         2, 1'b1, 32'h1, 1'b0);
      xact(0, 1'b0, 1'b1, 32'h1000, 32'h0,         2, 1'b1, 32'h0, 1'b1);

      // MOE and MWR together: performed as a write, flagged with MERR
      xact(0, 1'b1, 1'b1, 32'h8, 32'h55, 2, 1'b0, 32'h0, 1'b1);
      xact(0, 1'b0, 1'b1, 32'h8, 32'h0,  2, 1'b1, 32'h55, 1'b0);

      // WAIT_STATES=3 abort: MWR held 2 cycles then dropped in WAIT
      xact(2, 1'b1, 1'b0, 32'h20, 32'hA5A5, 5, 1'b0, 32'h0, 1'b0);
      xact(2, 1'b0, 1'b1, 32'h20, 32'h0,    5, 1'b1, 32'hA5A5, 1'b0);
      @(negedge clk);
      mwr[2] = 1'b1;
      ma[2]  = 32'h20;
      mwd[2] = 32'h1111;
      #1;
      check("abort_stall_c0", {31'b0, stall[2]}, 32'h1);
      @(negedge clk);
      #1;
      check("abort_stall_c1", {31'b0, stall[2]}, 32'h1);
      @(negedge clk);
      mwr[2] = 1'b0;
      @(negedge clk);
      #1;
      check("abort_stall_after", {31'b0, stall[2]}, 32'h0);
      check("abort_merr", {31'b0, merr[2]}, 32'h0);
      check("abort_mrd", mrd[2], 32'hA5A5);
      xact(2, 1'b0, 1'b1, 32'h20, 32'h0, 5, 1'b1, 32'hA5A5, 1'b0);

      // Reset mid-WAIT of a store to word 5
      xact(2, 1'b1, 1'b0, 32'h14, 32'h1234, 5, 1'b0, 32'h0, 1'b0);
      xact(2, 1'b0, 1'b1, 32'h14, 32'h0,    5, 1'b1, 32'h1234, 1'b0);
      @(negedge clk);
      mwr[2] = 1'b1;
      ma[2]  = 32'h14;
      mwd[2] = 32'h0BAD;
      @(negedge clk);
      rst_n[2] = 1'b0;
      #1;
      check("midrst_stall", {31'b0, stall[2]}, 32'h0);
      check("midrst_mrd", mrd[2], 32'h0);
      check("midrst_merr", {31'b0, merr[2]}, 32'h0);
      repeat (2) @(negedge clk);
      mwr[2] = 1'b0;
      rst_n[2] = 1'b1;
      @(negedge clk);
      xact(2, 1'b0, 1'b1, 32'h14, 32'h0, 5, 1'b1, 32'h1234, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/beta_dmem_resp.md
# beta_dmem_resp

Data-memory responder for the Beta datapath. It services the memory requests raised by the control unit: MOE for LD/LDR and MWR for ST. It holds a word-addressed on-chip RAM with a configurable number of wait states, and stalls the processor until each access completes. It sits between the ALU/register-file outputs (address, write data) and the WDSEL=2 input of the write-back mux.

## Interface
- DEPTH_LOG2, 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- WAIT_STATES, 1: extra cycles inserted before the access cycle; legal range 0..15.
- CLK  input  1  single clock, rising edge.
- RESET_N  input  1  reset, asynchronous and active-low.
- MOE  input  1  read request, level, from control unit.
- MWR  input  1  write request, level, from control unit.
- MA  input  32  byte address from ALU; MA[1:0] ignored.
- MWD  input  32  store data from register file (RD2).
- MRD  output  32  registered read data.
- STALL  output  1  high means the processor must hold PC and all state this cycle.
- MERR  output  1  one-cycle pulse on an address or request error.

## Operation
- Request = MOE | MWR, sampled each cycle.
- Write takes priority when MOE and MWR are both high; the access is performed as a write and MERR pulses in the DONE cycle.
- Word index = MA[DEPTH_LOG2+1:2].
  - Out of range: any of MA[31:DEPTH_LOG2+2] nonzero.
  - Out-of-range write is dropped.
  - Out-of-range read returns 32'h0.
  - MERR pulses in the DONE cycle for either case.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: if request, latch MA, MWD and op. Go to WAIT with cnt=WAIT_STATES-1, or to ACCESS when WAIT_STATES=0.
  - WAIT: cnt decrements; at cnt=0 go to ACCESS.
  - ACCESS: perform the RAM write, or load MRD from the RAM. Go to DONE.
  - DONE: go to IDLE unconditionally.
- STALL is combinational:
  - high in IDLE while a request is present;
  - high in WAIT and ACCESS;
  - low in DONE.
  - The processor therefore advances on the clock edge that ends DONE.
- Abort: if the request deasserts while in WAIT, or in the cycle entering ACCESS (e.g. IRQ forces MWR=0), return to IDLE. No write occurs, MRD is unchanged and MERR stays 0.
- Latched address and data are used throughout the transaction. Changes on MA/MWD after IDLE are ignored.
- MRD holds its value until the next completed read.
- RAM contents are not reset.

## Timing
- Reset values: state=IDLE, cnt=0, MRD=32'h0, MERR=0, STALL=0. No RAM write occurs while RESET_N is low.
- Reset asserted mid-transaction aborts it immediately; a pending write is never performed.
- Latency from the first request cycle to the DONE cycle is WAIT_STATES+2 cycles. STALL is high for WAIT_STATES+2 cycles (IDLE + waits + ACCESS).
  - WAIT_STATES=0: STALL high 2 cycles.
  - WAIT_STATES=1: STALL high 3 cycles.
- MRD is valid in the DONE cycle, registered at the end of ACCESS.
- A write is committed at the clock edge ending ACCESS.
- Back-to-back requests: the next instruction's request is seen in IDLE on the cycle after DONE. There are no idle gaps beyond that, and no request is ever accepted in DONE.
- MERR is high only in the DONE cycle of the faulting transaction.
- No request (ALU ops, branches): state stays IDLE and STALL=0. The block adds no cycles.

## Test plan
- Reset: drive RESET_N low mid-WAIT of a ST to word 5 -> STALL=0, MRD=0, MERR=0 immediately. A later LD of word 5 returns its old contents, not the store data.
- WAIT_STATES=1, ST MA=0x10, MWD=0xDEADBEEF, then LD MA=0x10:
  - each request holds STALL high for exactly 3 cycles;
  - LD DONE cycle shows MRD=0xDEADBEEF;
  - MERR=0 throughout.
- WAIT_STATES=0, back-to-back LDs of 0x0 and 0x4 (preloaded 1 and 2) -> MRD=1 then 2. STALL pattern 1,1,0,1,1,0.
- DEPTH_LOG2=10:
  - ST to MA=0x1000 -> MERR pulses once in DONE;
  - subsequent LD of 0x0 is unchanged;
  - LD MA=0x1000 -> MRD=0 with MERR pulse.
- Abort: ST with WAIT_STATES=3, drop MWR after 2 cycles -> state returns to IDLE, STALL=0 next cycle, and the target word is unchanged.
- MOE=MWR=1 at MA=0x8, MWD=0x55 -> word 2 becomes 0x55 and MERR pulses in DONE.
